// File: rtl/fir_tap_sequencer.sv
// -----------------------------------------------------------------------------
// fir_tap_sequencer
//
// Tap/channel sequencer for the FIR datapath. One round is requested with a
// start pulse, walks tap_index over 0..taps-1 for every TDM channel in turn,
// and ends with a one-cycle done pulse. The outputs address the coefficient
// ROM and the sample delay line, clear the MAC (phase_min) and dump the
// accumulator (phase_max).
//
// Optional feature macro: FIR_TAP_SEQ_SYMMETRIC_FOLD_EN
//   When defined, each channel sweeps only ceil(taps/2) taps for folded
//   pre-adder FIRs, mirror_index gives the partner tap and center_tap flags
//   the unpaired middle tap of an odd-length filter. When undefined the full
//   sweep is used and mirror_index/center_tap are tied to 0.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-low reset
//   clk_enable     advance qualifier; all state holds while low
//   start          request one round (sampled when clk_enable=1)
//   num_taps       taps per channel, latched on an accepted start
//   busy           round in progress
//   done           one-cycle pulse after the final tap
//   cfg_err        one-cycle pulse when a start carries an illegal num_taps
//   tap_valid      busy & clk_enable
//   tap_index      current tap
//   channel_index  current channel
//   phase_min      first tap of a channel sweep
//   phase_max      last tap of a channel sweep
//   last_tap       last tap of the last channel
//   mirror_index   folded partner tap
//   center_tap     unpaired middle tap flag
// -----------------------------------------------------------------------------
module fir_tap_sequencer #(
  parameter int MAX_TAPS     = 64,
  parameter int NUM_CHANNELS = 1,
  parameter int TAP_BITS     = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1,
  parameter int CH_BITS      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_enable,
  input  logic                start,
  input  logic [TAP_BITS:0]   num_taps,
  output logic                busy,
  output logic                done,
  output logic                cfg_err,
  output logic                tap_valid,
  output logic [TAP_BITS-1:0] tap_index,
  output logic [CH_BITS-1:0]  channel_index,
  output logic                phase_min,
  output logic                phase_max,
  output logic                last_tap,
  output logic [TAP_BITS-1:0] mirror_index,
  output logic                center_tap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [TAP_BITS:0]   MAX_TAPS_W = (TAP_BITS + 1)'(MAX_TAPS);
  localparam logic [TAP_BITS:0]   ONE_W      = (TAP_BITS + 1)'(1);
  localparam logic [CH_BITS-1:0]  LAST_CH    = CH_BITS'(NUM_CHANNELS - 1);

  state_t                state_q, state_d;
  logic [TAP_BITS-1:0]   tap_q, tap_d;
  logic [CH_BITS-1:0]    ch_q, ch_d;
  logic [TAP_BITS:0]     taps_q, taps_d;
  logic                  cfg_err_q, cfg_err_d;

  logic [TAP_BITS:0]     tap_ext;
  logic [TAP_BITS:0]     sweep_len;
  logic                  tap_at_end;
  logic                  ch_last;
  logic                  num_taps_ok;

  assign tap_ext = {1'b0, tap_q};

`ifdef FIR_TAP_SEQ_SYMMETRIC_FOLD_EN
  // Only the first half (rounded up) of the taps is walked; the pre-adder
  // supplies the mirrored sample.
  logic [TAP_BITS:0] mirror_full;

  assign sweep_len    = (taps_q + ONE_W) >> 1;
  assign mirror_full  = taps_q - ONE_W - tap_ext;
  assign mirror_index = mirror_full[TAP_BITS-1:0];
  assign center_tap   = taps_q[0] && (tap_ext == ((taps_q - ONE_W) >> 1));
`else
  assign sweep_len    = taps_q;
  assign mirror_index = '0;
  assign center_tap   = 1'b0;
`endif

  // taps_q is never 0 (reset value and every latched value are legal), so
  // sweep_len - 1 cannot underflow.
  assign tap_at_end  = (tap_ext == (sweep_len - ONE_W));
  assign ch_last     = (ch_q == LAST_CH);
  assign num_taps_ok = (num_taps != '0) && (num_taps <= MAX_TAPS_W);

  // Next-state logic. With clk_enable low every *_d equals its *_q, so the
  // whole block holds.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; that is what keeps this block free of latches.
    state_d   = state_q;
    tap_d     = tap_q;
    ch_d      = ch_q;
    taps_d    = taps_q;
    cfg_err_d = cfg_err_q;

    if (clk_enable) begin
      cfg_err_d = 1'b0;
      unique case (state_q)
        // DONE behaves exactly like IDLE for a new start, giving
        // back-to-back rounds with a single bubble cycle.
        IDLE, DONE: begin
          state_d = IDLE;
          if (start) begin
            if (num_taps_ok) begin
              taps_d  = num_taps;
              tap_d   = '0;
              ch_d    = '0;
              state_d = RUN;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (tap_at_end) begin
            tap_d = '0;
            ch_d  = ch_last ? '0 : ch_q + CH_BITS'(1);
            if (ch_last) begin
              state_d = DONE;
            end
          end else begin
            tap_d = tap_q + TAP_BITS'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: the reset is sampled inside the clocked block, so it is
  // synchronous; every register here is plain control state and is reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so all
      // registers update together from the values before the edge.
      state_q   <= IDLE;
      tap_q     <= '0;
      ch_q      <= '0;
      taps_q    <= MAX_TAPS_W;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      ch_q      <= ch_d;
      taps_q    <= taps_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign busy          = (state_q == RUN);
  assign tap_valid     = busy && clk_enable;
  assign done          = (state_q == DONE) && clk_enable;
  assign cfg_err       = cfg_err_q && clk_enable;
  assign tap_index     = tap_q;
  assign channel_index = ch_q;
  assign phase_min     = tap_valid && (tap_q == '0);
  assign phase_max     = tap_valid && tap_at_end;
  assign last_tap      = phase_max && ch_last;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fir_tap_sequencer
//
// Self-checking bench for fir_tap_sequencer with MAX_TAPS=16, NUM_CHANNELS=2.
// A behavioural model tracks a round as a linear position k within
// sweep*NUM_CHANNELS cycles; the expected tap/channel are k mod/div sweep.
// Directed sequences pin known literal values; a random phase follows.
// -----------------------------------------------------------------------------
module tb_fir_tap_sequencer;

  localparam int MT = 16;
  localparam int NC = 2;
  localparam int TB = 4;
  localparam int CB = 1;

  logic          clk;
  logic          rst;
  logic          clk_enable;
  logic          start;
  logic [TB:0]   num_taps;
  logic          busy, done, cfg_err, tap_valid;
  logic [TB-1:0] tap_index;
  logic [CB-1:0] channel_index;
  logic          phase_min, phase_max, last_tap;
  logic [TB-1:0] mirror_index;
  logic          center_tap;

  fir_tap_sequencer #(
    .MAX_TAPS    (MT),
    .NUM_CHANNELS(NC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_enable   (clk_enable),
    .start        (start),
    .num_taps     (num_taps),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err),
    .tap_valid    (tap_valid),
    .tap_index    (tap_index),
    .channel_index(channel_index),
    .phase_min    (phase_min),
    .phase_max    (phase_max),
    .last_tap     (last_tap),
    .mirror_index (mirror_index),
    .center_tap   (center_tap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
`ifdef FIR_TAP_SEQ_SYMMETRIC_FOLD_EN
  localparam bit FOLD = 1'b1;
`else
  localparam bit FOLD = 1'b0;
`endif

  function automatic int sweep_of(input int taps);
    return FOLD ? (taps + 1) / 2 : taps;
  endfunction

  int m_taps = MT;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  bit m_cfg  = 1'b0;
  int m_k    = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_taps = MT;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_cfg  = 1'b0;
      m_k    = 0;
    end else if (clk_enable) begin
      if (m_busy) begin
        m_cfg = 1'b0;
        m_k++;
        if (m_k == sweep_of(m_taps) * NC) begin
          m_busy = 1'b0;
          m_k    = 0;
          m_done = 1'b1;
        end
      end else begin
        m_done = 1'b0;
        m_cfg  = 1'b0;
        if (start) begin
          if (num_taps >= 1 && num_taps <= MT) begin
            m_busy = 1'b1;
            m_k    = 0;
            m_taps = int'(num_taps);
          end else begin
            m_cfg = 1'b1;
          end
        end
      end
    end
  end

  // Compare process: every negative edge while enabled.
  always @(negedge clk) begin
    int sw, e_tap, e_ch, e_mir;
    bit en, e_valid, e_cen;
    if (cmp_en) begin
      en      = clk_enable;
      sw      = sweep_of(m_taps);
      e_tap   = m_busy ? m_k % sw : 0;
      e_ch    = m_busy ? m_k / sw : 0;
      e_valid = m_busy && en;
      e_mir   = FOLD ? m_taps - 1 - e_tap : 0;
      e_cen   = FOLD && (m_taps % 2 == 1) && (e_tap == (m_taps - 1) / 2);
      check("busy",          busy,          m_busy);
      check("tap_valid",     tap_valid,     e_valid);
      check("done",          done,          m_done && en);
      check("cfg_err",       cfg_err,       m_cfg && en);
      check("tap_index",     tap_index,     e_tap);
      check("channel_index", channel_index, e_ch);
      check("phase_min",     phase_min,     e_valid && e_tap == 0);
      check("phase_max",     phase_max,     e_valid && e_tap == sw - 1);
      check("last_tap",      last_tap,      e_valid && m_k == sw * NC - 1);
      check("mirror_index",  mirror_index,  e_mir);
      check("center_tap",    center_tap,    e_cen);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus and literal checks
  // ---------------------------------------------------------------------------
  int  exp_tap[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
  int  exp_ch[8]   = '{0, 0, 0, 0, 1, 1, 1, 1};
  bit  exp_pmin[8] = '{1, 0, 0, 0, 1, 0, 0, 0};
  bit  exp_last[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
  bit  b2b_busy[14] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  bit  b2b_done[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int  fold_mir[4] = '{6, 5, 4, 3};
  bit  fold_cen[4] = '{0, 0, 0, 1};

  task automatic run_to_done(input string name, input int exp_len);
    int  len;
    bit  seen;
    len  = 0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (tap_valid) len++;
      if (done) seen = 1'b1;
      tick();
    end
    check({name, "_done_seen"}, seen, 1'b1);
    check({name, "_len"}, len, exp_len);
  endtask

  initial begin
    int vcount;
    bit vdone;

    rst        = 1'b0;
    clk_enable = 1'b1;
    start      = 1'b0;
    num_taps   = '0;
    tick();
    tick();
    cmp_en = 1'b1;
    tick();
    rst = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_busy",    busy, 1'b0);
    check("rst_tap",     tap_index, 0);
    check("rst_ch",      channel_index, 0);
    check("rst_done",    done, 1'b0);
    check("rst_cfg_err", cfg_err, 1'b0);
    tick();

    // Basic 4-tap, 2-channel round
    num_taps = 5'd4;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("r1_busy", busy, 1'b1);
      check("r1_tap",  tap_index, exp_tap[i]);
      check("r1_ch",   channel_index, exp_ch[i]);
      check("r1_pmin", phase_min, exp_pmin[i]);
      check("r1_last", last_tap, exp_last[i]);
      tick();
    end
    @(negedge clk);
    check("r1_done", done, 1'b1);
    check("r1_busy_end", busy, 1'b0);
    tick();
    @(negedge clk);
    check("r1_done_gone", done, 1'b0);

    // Illegal tap counts
    num_taps = 5'd0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("cfg0_err",  cfg_err, 1'b1);
    check("cfg0_busy", busy, 1'b0);
    tick();
    @(negedge clk);
    check("cfg0_clear", cfg_err, 1'b0);
    num_taps = 5'd17;
    start    = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("cfg17_err",  cfg_err, 1'b1);
    check("cfg17_busy", busy, 1'b0);
    tick();
    @(negedge clk);
    check("cfg17_clear", cfg_err, 1'b0);
    check("cfg17_idle",  busy, 1'b0);
    tick();

    // Single-tap round: phase_min and phase_max on every tap
    num_taps = 5'd1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t1_pmin", phase_min, 1'b1);
      check("t1_pmax", phase_max, 1'b1);
      tick();
    end
    tick();

    // clk_enable toggling during a 3-tap round
    num_taps = 5'd3;
    start    = 1'b1;
    tick();
    start  = 1'b0;
    vcount = 0;
    vdone  = 1'b0;
    for (int c = 0; c < 40 && !vdone; c++) begin
      clk_enable = (c % 2 == 0);
      @(negedge clk);
      if (!clk_enable) check("en_valid_low", tap_valid, 1'b0);
      if (tap_valid) vcount++;
      if (done) vdone = 1'b1;
      tick();
    end
    clk_enable = 1'b1;
    check("en_done_seen", vdone, 1'b1);
    check("en_valid_cnt", vcount, 3 * NC);
    tick();

    // Reset in the middle of a 16-tap round
    num_taps = 5'd16;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort_tap5", tap_index, 5);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("abort_tap",  tap_index, 0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
    end
    tick();
    num_taps = 5'd16;
    start    = 1'b1;
    tick();
    start = 1'b0;
    run_to_done("rerun16", sweep_of(16) * NC);

    // Start held through DONE, num_taps changed mid-round
    num_taps = 5'd4;
    start    = 1'b1;
    tick();
    for (int i = 0; i < 14; i++) begin
      if (i == 3) num_taps = 5'd2;
      if (i == 9) start = 1'b0;
      @(negedge clk);
      check("b2b_busy", busy, b2b_busy[i]);
      check("b2b_done", done, b2b_done[i]);
      tick();
    end

`ifdef FIR_TAP_SEQ_SYMMETRIC_FOLD_EN
    // Folded 7-tap round
    num_taps = 5'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fold_tap", tap_index, i);
      check("fold_mir", mirror_index, fold_mir[i]);
      check("fold_cen", center_tap, fold_cen[i]);
      tick();
    end
    run_to_done("fold7_rest", 4);
`endif

    // Randomized phase
    for (int c = 0; c < 1500; c++) begin
      clk_enable = ($urandom_range(0, 3) != 0);
      start      = ($urandom_range(0, 9) < 3);
      num_taps   = 5'($urandom_range(0, 18));
      rst        = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst        = 1'b1;
    start      = 1'b0;
    clk_enable = 1'b1;
    repeat (3) tick();

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
